// File: rtl/seq_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : seq_event_monitor
// Brief    : Windowed event counter for the sequence-detector output.
//            Reports a per-window hit count, raises a sticky threshold
//            alarm, and keeps a saturating lifetime event total.
// Revision : 1.0 - initial release
// ============================================================================
module seq_event_monitor #(
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 4,
  parameter int CNT_W   = 8,
  parameter int TOT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             det,
  input  logic             clr_alarm,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm,
  output logic [TOT_W-1:0] total,
  output logic             busy
);

  localparam int TMR_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [TMR_W-1:0] C_LAST    = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] C_TOT_MAX = {TOT_W{1'b1}};
  // A threshold above the saturated count can never be reached; keep the
  // compare in range and gate it off instead of truncating THRESH.
  localparam bit               C_THR_OK  = (THRESH <= ((2 ** CNT_W) - 1));
  localparam logic [CNT_W-1:0] C_THRESH  = C_THR_OK ? CNT_W'(THRESH) : C_CNT_MAX;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_acc;

  logic             w_count_en;
  logic             w_last;
  logic             w_set_alarm;
  logic [CNT_W-1:0] w_acc_inc;
  logic [TOT_W-1:0] w_tot_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_count_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // det is deliberately ignored here, even on the enabling cycle
        if (en) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (en) begin
          w_count_en = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_last      = w_count_en && (r_timer == C_LAST);
    w_acc_inc   = (r_acc == C_CNT_MAX) ? r_acc : (r_acc + CNT_W'(det));
    w_tot_inc   = (total == C_TOT_MAX) ? total : (total + TOT_W'(det));
    // The reported value is the accumulator including this cycle's det
    w_set_alarm = w_last && C_THR_OK && (w_acc_inc >= C_THRESH);
  end

  // Window timer, accumulator, report, lifetime total and alarm
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_acc     <= '0;
      win_count <= '0;
      win_valid <= 1'b0;
      alarm     <= 1'b0;
      total     <= '0;
    end else begin
      win_valid <= 1'b0;
      if (w_count_en) begin
        total <= w_tot_inc;
        if (w_last) begin
          // Back-to-back windows: restart immediately with no gap
          r_timer   <= '0;
          r_acc     <= '0;
          win_count <= w_acc_inc;
          win_valid <= 1'b1;
        end else begin
          r_timer <= r_timer + TMR_W'(1);
          r_acc   <= w_acc_inc;
        end
      end else begin
        // Idle or aborted window: partial count is discarded
        r_timer <= '0;
        r_acc   <= '0;
      end

      // Set has priority over a coincident clear
      if (w_set_alarm) begin
        alarm <= 1'b1;
      end else if (clr_alarm) begin
        alarm <= 1'b0;
      end
    end
  end

  assign busy = (r_state == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_seq_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_event_monitor
// Brief    : Scoreboard bench for seq_event_monitor. Two instances share all
//            inputs: CNT_W=4 (unsaturated) and CNT_W=2 (saturates at 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_event_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        det;
  logic        clr_alarm;

  logic [3:0]  win_count_a;
  logic        win_valid_a;
  logic        alarm_a;
  logic [15:0] total_a;
  logic        busy_a;

  logic [1:0]  win_count_b;
  logic        win_valid_b;
  logic        alarm_b;
  logic [15:0] total_b;
  logic        busy_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int cnt;
    int alarm;
    int total;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  seq_event_monitor #(.WIN_LEN(8), .THRESH(3), .CNT_W(4), .TOT_W(16)) dut_a (
    .clk(clk), .reset(reset), .en(en), .det(det), .clr_alarm(clr_alarm),
    .win_count(win_count_a), .win_valid(win_valid_a), .alarm(alarm_a),
    .total(total_a), .busy(busy_a)
  );

  seq_event_monitor #(.WIN_LEN(8), .THRESH(3), .CNT_W(2), .TOT_W(16)) dut_b (
    .clk(clk), .reset(reset), .en(en), .det(det), .clr_alarm(clr_alarm),
    .win_count(win_count_b), .win_valid(win_valid_b), .alarm(alarm_b),
    .total(total_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected reports
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic e, input logic d, input logic c);
    en        = e;
    det       = d;
    clr_alarm = c;
    @(posedge clk);
    #1;
  endtask

  // One full 8-cycle window; the report is expected right after the last edge
  task automatic window(input logic [7:0] pat, input logic [7:0] clrm,
                        input int ca, input int cb, input int al, input int tot);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        e.cyc = cyc + 1; e.cnt = ca; e.alarm = al; e.total = tot;
        qa.push_back(e);
        e.cnt = cb;
        qb.push_back(e);
      end
      drive(1'b1, pat[i], clrm[i]);
    end
  endtask

  // Monitor for instance A
  always @(negedge clk) begin
    exp_t e;
    if (win_valid_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_report_cycle", cyc, e.cyc);
        chk("a_win_count", int'(win_count_a), e.cnt);
        chk("a_alarm", int'(alarm_a), e.alarm);
        chk("a_total", int'(total_a), e.total);
      end
    end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      chk("a_missing_valid", 0, 1);
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    exp_t e;
    if (win_valid_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_report_cycle", cyc, e.cyc);
        chk("b_win_count", int'(win_count_b), e.cnt);
        chk("b_alarm", int'(alarm_b), e.alarm);
        chk("b_total", int'(total_b), e.total);
      end
    end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      chk("b_missing_valid", 0, 1);
    end
  end

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_count_a"}, int'(win_count_a), 0);
    chk({tag, "_valid_a"}, int'(win_valid_a), 0);
    chk({tag, "_alarm_a"}, int'(alarm_a), 0);
    chk({tag, "_total_a"}, int'(total_a), 0);
    chk({tag, "_busy_a"},  int'(busy_a), 0);
    chk({tag, "_count_b"}, int'(win_count_b), 0);
    chk({tag, "_total_b"}, int'(total_b), 0);
    chk({tag, "_busy_b"},  int'(busy_b), 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; det = 1'b0; clr_alarm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("rst");
    reset = 1'b0;

    // Enable: first cycle only leaves IDLE, det ignored
    drive(1'b1, 1'b1, 1'b0);
    chk("busy_after_en", int'(busy_a), 1);
    chk("total_idle_det", int'(total_a), 0);

    // Quiet windows, then mixed patterns
    window(8'h00, 8'h00, 0, 0, 0, 0);
    window(8'h00, 8'h00, 0, 0, 0, 0);
    window(8'h89, 8'h00, 3, 3, 1, 3);    // det on cycles 0,3,7
    window(8'hFF, 8'h00, 8, 3, 1, 11);   // B saturates at 3
    window(8'h1F, 8'h80, 5, 3, 1, 16);   // clear coincides with set: set wins

    // Abort at timer=5 after two events; det on the abort cycle not counted
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_count_hold_a", int'(win_count_a), 5);
    chk("abort_count_hold_b", int'(win_count_b), 3);
    chk("abort_alarm_hold", int'(alarm_a), 1);
    chk("abort_total", int'(total_a), 18);

    // Clear in IDLE
    drive(1'b0, 1'b1, 1'b1);
    chk("idle_clr_alarm", int'(alarm_a), 0);
    chk("idle_total", int'(total_a), 18);

    // Re-enable: fresh window from timer 0
    drive(1'b1, 1'b1, 1'b0);
    chk("reen_busy", int'(busy_a), 1);
    window(8'h00, 8'h00, 0, 0, 0, 18);
    window(8'h89, 8'h00, 3, 3, 1, 21);
    window(8'h00, 8'h04, 0, 0, 0, 21);   // quiet-cycle clear

    // Partial window, then reset mid-window with det high
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("partial_total", int'(total_a), 24);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    chk_idle_zero("midrst");
    repeat (10) drive(1'b0, 1'b1, 1'b0);
    chk("post_rst_total", int'(total_a), 0);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
